// File: rtl/key_rev_sched.sv
// Round-key reversal buffer: captures a forward key schedule, then replays it
// last-to-first for decryption, optionally removing the round-counter XOR.
module key_rev_sched #(
  parameter int DEPTH    = 32,
  parameter bit STRIP_RC = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_valid,
  input  logic [0:63] wr_key,
  input  logic [0:5]  wr_round,
  input  logic        wr_last,
  output logic        wr_ready,
  output logic        rd_valid,
  output logic [0:63] rd_key,
  output logic [0:5]  rd_round,
  output logic        rd_last,
  input  logic        rd_ready,
  output logic        busy,
  output logic        seq_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

  state_t          state_q;
  logic [6:0]      count_q;
  logic [AW-1:0]   ptr_q;
  logic            seq_err_q;
  logic            rd_valid_q;
  logic [0:63]     rd_key_q;
  logic [0:5]      rd_round_q;
  logic            rd_last_q;

  logic [0:63]     mem_key   [DEPTH];
  logic [0:5]      mem_round [DEPTH];

  logic            wr_hs;
  logic [AW-1:0]   wr_slot;
  logic [6:0]      count_base;
  logic [6:0]      count_d;
  logic            mismatch;
  logic            to_drain;
  logic            load;
  logic [0:63]     rd_key_d;
  logic [0:5]      rd_round_d;
  logic            rd_last_d;

  // Undo the round-counter injection on the top five key bits.
  function automatic logic [0:63] strip_rc(input logic [0:63] k, input logic [0:5] r);
    logic [0:63] f;
    f = k;
    if (STRIP_RC) f[0:4] = k[0:4] ^ r[1:5];
    return f;
  endfunction

  assign wr_ready   = (state_q != DRAIN);
  assign busy       = (state_q != IDLE);
  assign wr_hs      = wr_valid & wr_ready;
  assign count_base = (state_q == IDLE) ? 7'd0 : count_q;
  assign wr_slot    = count_base[AW-1:0];
  assign count_d    = count_base + 7'd1;
  assign mismatch   = ({1'b0, wr_round} != count_base);
  assign to_drain   = wr_last || (count_d == 7'(DEPTH));

  always_ff @(posedge clk) begin
    if (wr_hs) begin
      mem_key[wr_slot]   <= wr_key;
      mem_round[wr_slot] <= wr_round;
    end
  end

  always_comb begin
    rd_key_d   = strip_rc(mem_key[ptr_q], mem_round[ptr_q]);
    rd_round_d = mem_round[ptr_q];
    rd_last_d  = (ptr_q == '0);
  end

  // Refill the output register when it is empty or being consumed, until slot 0 is out.
  assign load = (state_q == DRAIN) && (!rd_valid_q || rd_ready) && !(rd_valid_q && rd_last_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      count_q    <= '0;
      ptr_q      <= '0;
      seq_err_q  <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_key_q   <= '0;
      rd_round_q <= '0;
      rd_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_hs) begin
            count_q   <= count_d;
            ptr_q     <= wr_slot;
            seq_err_q <= mismatch;
            state_q   <= to_drain ? DRAIN : FILL;
          end
        end
        FILL: begin
          if (wr_hs) begin
            count_q <= count_d;
            ptr_q   <= wr_slot;
            if (mismatch) seq_err_q <= 1'b1;
            if (to_drain) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (rd_valid_q && rd_ready && rd_last_q) begin
            state_q    <= IDLE;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
            count_q    <= '0;
          end else if (load) begin
            rd_valid_q <= 1'b1;
            rd_key_q   <= rd_key_d;
            rd_round_q <= rd_round_d;
            rd_last_q  <= rd_last_d;
            if (ptr_q != '0) ptr_q <= ptr_q - AW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign rd_valid = rd_valid_q;
  assign rd_key   = rd_key_q;
  assign rd_round = rd_round_q;
  assign rd_last  = rd_last_q;
  assign seq_err  = seq_err_q;

endmodule

// File: doc/key_rev_sched.md
KEY_REV_SCHED -- requirements
Module: key_rev_sched

Interface
REQ-001 Parameter DEPTH, default 32: maximum number of round keys held (1..64).
REQ-002 Parameter STRIP_RC, default 1: when 1, remove the round-counter XOR from bits [0:4] of each emitted key.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-high.
REQ-005 wr_valid  input  1  forward round key offered.
REQ-006 wr_key  input  [0:63]  forward round key, {row3,row2,row1,row0} ordering of the expansion round.
REQ-007 wr_round  input  [0:5]  round index i used when wr_key was produced.
REQ-008 wr_last  input  1  marks final forward round key of the schedule.
REQ-009 wr_ready  output  1  block accepts wr_* this cycle.
REQ-010 rd_valid  output  1  reverse-order round key available.
REQ-011 rd_key  output  [0:63]  round key for decryption.
REQ-012 rd_round  output  [0:5]  round index of rd_key.
REQ-013 rd_last  output  1  marks round 0 key, final of reverse sequence.
REQ-014 rd_ready  input  1  consumer accepts rd_* this cycle.
REQ-015 busy  output  1  high in FILL or DRAIN.
REQ-016 seq_err  output  1  sticky: a wr_round arrived out of sequence.

Function
REQ-017 FSM states IDLE, FILL, DRAIN; encoding is implementer's choice.
REQ-018 Write handshake = wr_valid & wr_ready; read handshake = rd_valid & rd_ready.
REQ-019 wr_ready = 1 in IDLE and FILL, 0 in DRAIN.
REQ-020 IDLE: a write handshake stores the key at slot 0, count:=1, clears seq_err, goes to FILL (or DRAIN if wr_last or DEPTH=1).
REQ-021 FILL: each write handshake stores at slot count, count:=count+1.
REQ-022 Expected round of each accepted key = its slot index; mismatch sets seq_err, key still stored with its received wr_round.
REQ-023 FILL -> DRAIN after a handshake with wr_last=1 or when count reaches DEPTH; wr_last takes precedence, no further writes accepted.
REQ-024 DRAIN: slots read from highest index (count-1) down to 0; one key per read handshake.
REQ-025 Output stage registered: rd_valid rises the cycle after DRAIN entry; no combinational path wr_* -> rd_*.
REQ-026 Under rd_valid=1 & rd_ready=0, rd_key/rd_round/rd_last hold stable.
REQ-027 rd_ready=1 continuously sustains one key per cycle (no bubbles) after the first.
REQ-028 rd_round = stored wr_round of the slot; rd_last=1 exactly on slot 0.
REQ-029 STRIP_RC=1: rd_key[0:4] = stored[0:4] ^ stored_round[1:5]; rd_key[5:63] = stored[5:63]. STRIP_RC=0: rd_key = stored key unmodified.
REQ-030 Read handshake with rd_last=1 -> IDLE next cycle, rd_valid:=0, count:=0; seq_err retained until next IDLE write.
REQ-031 Writes in DRAIN are ignored (wr_ready=0); wr_valid in IDLE with wr_last=1 yields single-key schedule.
REQ-032 busy = (state != IDLE).

Reset
REQ-033 rst asserted: state:=IDLE, count:=0, rd_valid:=0, rd_last:=0, rd_key:=0, rd_round:=0, seq_err:=0, busy:=0, wr_ready:=1 (after rst release).
REQ-034 Reset mid-FILL or mid-DRAIN abandons stored keys; no rd_valid until a new schedule is filled.
REQ-035 Storage array contents need not be reset.

Verification
REQ-036 Write rounds 0..3 keys K0..K3 (K3 with wr_last), rd_ready=1 -> rd sequence K3,K2,K1,K0 rounds 3,2,1,0, rd_last only on K0, then IDLE.
REQ-037 STRIP_RC=1, key 64'hFFFF_0000_0000_0000 at round 6'd5 -> rd_key = 64'h D7FF_0000_0000_0000 (bits[0:4] 11111^00101=11010).
REQ-038 Fill DEPTH=32 keys without wr_last -> auto DRAIN after 32nd, wr_ready=0, 32 reads, rd_last on round 0.
REQ-039 Rounds 0,1,3 written -> seq_err=1 after third write, keys still drained 3,1,0; seq_err clears on next schedule's first write.
REQ-040 rd_ready toggled 1,0,0,1 during DRAIN -> rd_key stable across stalled cycles, no key lost or duplicated.
REQ-041 rst pulsed mid-DRAIN after 2 reads -> rd_valid=0, busy=0 immediately; new 2-key schedule drains correctly.
